ifd_mem_stim_bfm: RTL

//  Parametrised memory bus functional model for IFD/EXEC unit-level benches; it sits on the IFU read port in place of memory.

---
 rtl/ifd_mem_stim_bfm.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ifd_mem_stim_bfm.sv
// Memory bus functional model for the IFU read port: returns seeded, repeatable instruction
// words (forced first word, directed FIFO, LFSR, address echo or hold) after a fixed latency.
module ifd_mem_stim_bfm #(
  parameter int unsigned           DATA_WIDTH  = 12,
  parameter int unsigned           ADDR_WIDTH  = 12,
  parameter int unsigned           RD_LATENCY  = 1,
  parameter int unsigned           DIR_DEPTH   = 8,
  parameter logic [15:0]           LFSR_SEED   = 16'hACE1,
  parameter bit                    FIRST_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] FIRST_INSTR = 12'o7200,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD   = 12'o7402
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [1:0]                   mode,
  input  logic                         dir_wr_en,
  input  logic [DATA_WIDTH-1:0]        dir_wr_data,
  output logic                         dir_full,
  output logic [$clog2(DIR_DEPTH):0]   dir_count,
  output logic                         dir_overflow,
  input  logic                         ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0]        ifu_rd_addr,
  output logic [DATA_WIDTH-1:0]        ifu_rd_data,
  output logic                         ifu_rd_valid,
  output logic [15:0]                  req_count
);

  localparam int unsigned PtrW    = $clog2(DIR_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {
    ModeRandom   = 2'd0,
    ModeDirected = 2'd1,
    ModeAddrEcho = 2'd2,
    ModeHold     = 2'd3
  } mode_e;

  logic [DATA_WIDTH-1:0] fifo_mem_q [DIR_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic                  first_q, first_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [15:0]           req_cnt_q, req_cnt_d;
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [DATA_WIDTH-1:0] pipe_data_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data_d [RD_LATENCY];

  logic                  fifo_empty, fifo_full;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] echo_word;
  logic [DATA_WIDTH-1:0] lfsr_word;
  logic [DATA_WIDTH-1:0] rand_word;

  if (ADDR_WIDTH >= DATA_WIDTH) begin : g_echo_trunc
    assign echo_word = ifu_rd_addr[DATA_WIDTH-1:0];
  end else begin : g_echo_zext
    assign echo_word = {{(DATA_WIDTH - ADDR_WIDTH){1'b0}}, ifu_rd_addr};
  end

  if (DATA_WIDTH <= 16) begin : g_lfsr_trunc
    assign lfsr_word = lfsr_q[DATA_WIDTH-1:0];
  end else begin : g_lfsr_zext
    assign lfsr_word = {{(DATA_WIDTH - 16){1'b0}}, lfsr_q};
  end

  // All-ones is reserved so the random stream never produces that word.
  assign rand_word  = (lfsr_word == '1) ? '0 : lfsr_word;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(DIR_DEPTH));

  always_comb begin
    word    = last_q;
    pop     = 1'b0;
    lfsr_d  = lfsr_q;
    first_d = first_q;
    if (ifu_rd_req) begin
      case (mode_e'(mode))
        ModeRandom: begin
          if (first_q) begin
            word    = FIRST_INSTR;
            first_d = 1'b0;
          end else if (!fifo_empty) begin
            word = fifo_mem_q[rd_ptr_q];
            pop  = 1'b1;
          end else begin
            word   = rand_word;
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
          end
        end
        ModeDirected: begin
          if (!fifo_empty) begin
            word = fifo_mem_q[rd_ptr_q];
            pop  = 1'b1;
          end else begin
            word = HALT_WORD;
          end
        end
        ModeAddrEcho: word = echo_word;
        default:      word = last_q;
      endcase
    end
  end

  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    push       = dir_wr_en && (!fifo_full || pop);
    overflow_d = overflow_q | (dir_wr_en && fifo_full && !pop);
    wr_ptr_d   = push ? PtrW'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d   = pop ? PtrW'(rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = CntW'(count_q + 1'b1);
    end else if (pop && !push) begin
      count_d = CntW'(count_q - 1'b1);
    end
    last_d    = ifu_rd_req ? word : last_q;
    req_cnt_d = ifu_rd_req ? 16'(req_cnt_q + 16'd1) : req_cnt_q;
  end

  // Each stage only loads when the stage before it is valid, so the last stage holds its data.
  always_comb begin
    pipe_vld_d     = '0;
    pipe_vld_d[0]  = ifu_rd_req;
    pipe_data_d[0] = ifu_rd_req ? word : pipe_data_q[0];
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_data_d[i] = pipe_vld_q[i-1] ? pipe_data_q[i-1] : pipe_data_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= dir_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      lfsr_q     <= SeedEff;
      first_q    <= FIRST_EN;
      last_q     <= '0;
      req_cnt_q  <= '0;
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      lfsr_q     <= lfsr_d;
      first_q    <= first_d;
      last_q     <= last_d;
      req_cnt_q  <= req_cnt_d;
      pipe_vld_q <= pipe_vld_d;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        pipe_data_q[i] <= pipe_data_d[i];
      end
    end
  end

  assign dir_full     = fifo_full;
  assign dir_count    = count_q;
  assign dir_overflow = overflow_q;
  assign ifu_rd_valid = pipe_vld_q[RD_LATENCY-1];
  assign ifu_rd_data  = pipe_data_q[RD_LATENCY-1];
  assign req_count    = req_cnt_q;

endmodule
